// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock line FIFO pointer controllers.
// Holds the default pointer width and the Gray/binary conversion helpers
// used by both the write-side (fifo_wptr_full) and read-side (fifo_rptr_empty) logic.
package fifo_pkg;

    // Default storage address width: 2**10 = 1024 entries.
    localparam int FIFO_PTR_WD = 10;

    // Working width of the conversion helpers. Callers zero-extend their
    // pointer into this width and slice the result back down; because the
    // upper bits are zero, both conversions give the same low bits as a
    // conversion done at the caller's exact width, so one function serves
    // any pointer width up to FUNC_WD.
    localparam int FUNC_WD = 32;

    function automatic logic [FUNC_WD-1:0] bin2gray(input logic [FUNC_WD-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down, done as a log-depth shift cascade.
    function automatic logic [FUNC_WD-1:0] gray2bin(input logic [FUNC_WD-1:0] gray);
        logic [FUNC_WD-1:0] bin;
        bin = gray;
        bin = bin ^ (bin >> 1);
        bin = bin ^ (bin >> 2);
        bin = bin ^ (bin >> 4);
        bin = bin ^ (bin >> 8);
        bin = bin ^ (bin >> 16);
        return bin;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a multi-bit Gray-coded bus crossing into clk.
// Ports: clk/rst (async active-high reset), d (asynchronous input), q (synchronised output).
// Latency: 2 clk cycles from d to q. No flow control.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] rq1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq1 <= '0;
            q   <= '0;
        end else begin
            rq1 <= d;
            q   <= rq1;
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag controller of the dual-clock line FIFO.
// Ports: wclk_i/wrst_i; wr_req_i in, wen_o/waddr_o to storage; wptr_gray_o to read domain;
//        rptr_gray_i from read domain; full_o/afull_o/wcount_o/overflow_o status; overflow_clr_i.
// Latency: wen_o combinational from wr_req_i; status registered; full release lags reads by 3 cycles.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int PTR_WD    = FIFO_PTR_WD,
    parameter int AFULL_THR = 1020
) (
    input  logic              wclk_i,
    input  logic              wrst_i,
    input  logic              wr_req_i,
    input  logic [PTR_WD:0]   rptr_gray_i,
    output logic              wen_o,
    output logic [PTR_WD-1:0] waddr_o,
    output logic [PTR_WD:0]   wptr_gray_o,
    output logic              full_o,
    output logic              afull_o,
    output logic [PTR_WD:0]   wcount_o,
    output logic              overflow_o,
    input  logic              overflow_clr_i
);

    // Threshold sized to the level width; legal values 1..DEPTH always fit.
    localparam logic [PTR_WD:0] AFULL_LVL = (PTR_WD+1)'(AFULL_THR);

    logic [PTR_WD:0]  wbin;
    logic [PTR_WD:0]  wgray;
    logic [PTR_WD:0]  wbin_next;
    logic [PTR_WD:0]  wgray_next;
    logic [PTR_WD:0]  rq2;
    logic [PTR_WD:0]  rbin_s;
    logic [PTR_WD:0]  level_next;
    logic [PTR_WD:0]  full_gray;
    logic [FUNC_WD-1:0] b2g_wide;
    logic [FUNC_WD-1:0] g2b_wide;

    // Only the second stage of the synchroniser is ever consumed.
    sync_2ff #(
        .WIDTH (PTR_WD + 1)
    ) u_rptr_sync (
        .clk (wclk_i),
        .rst (wrst_i),
        .d   (rptr_gray_i),
        .q   (rq2)
    );

    always_comb begin
        // Reset gates the enable explicitly: full_o is already 0 in reset,
        // so without this term a held wr_req_i would write during reset.
        wen_o      = wr_req_i & ~full_o & ~wrst_i;
        wbin_next  = wbin + {{PTR_WD{1'b0}}, wen_o};
        b2g_wide   = bin2gray(FUNC_WD'(wbin_next));
        wgray_next = b2g_wide[PTR_WD:0];
        g2b_wide   = gray2bin(FUNC_WD'(rq2));
        rbin_s     = g2b_wide[PTR_WD:0];
        // Modulo subtraction of the extra-wrap-bit pointers yields 0..DEPTH.
        level_next = wbin_next - rbin_s;
        // Full when write pointer is exactly one lap ahead of the read pointer:
        // in Gray code that is the top two bits inverted, the rest equal.
        full_gray  = {~rq2[PTR_WD:PTR_WD-1], rq2[PTR_WD-2:0]};
    end

    assign waddr_o     = wbin[PTR_WD-1:0];
    assign wptr_gray_o = wgray;

    always_ff @(posedge wclk_i or posedge wrst_i) begin
        if (wrst_i) begin
            wbin       <= '0;
            wgray      <= '0;
            full_o     <= 1'b0;
            afull_o    <= 1'b0;
            wcount_o   <= '0;
            overflow_o <= 1'b0;
        end else begin
            wbin       <= wbin_next;
            wgray      <= wgray_next;
            full_o     <= (wgray_next == full_gray);
            afull_o    <= (level_next >= AFULL_LVL);
            wcount_o   <= level_next;
            // Set has priority over clear so a refused write is never lost.
            overflow_o <= (wr_req_i & full_o) | (overflow_o & ~overflow_clr_i);
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (PTR_WD=4, DEPTH=16, AFULL_THR=14).
// Expected write addresses are queued when a write is driven and popped when wen_o fires.
// Inputs change 1 time unit after the rising edge; outputs are sampled away from the edge.
module tb_fifo_wptr_full;

    localparam int PTR_WD    = 4;
    localparam int DEPTH     = 16;
    localparam int AFULL_THR = 14;

    logic              wclk_i = 1'b0;
    logic              wrst_i;
    logic              wr_req_i;
    logic [PTR_WD:0]   rptr_gray_i;
    logic              wen_o;
    logic [PTR_WD-1:0] waddr_o;
    logic [PTR_WD:0]   wptr_gray_o;
    logic              full_o;
    logic              afull_o;
    logic [PTR_WD:0]   wcount_o;
    logic              overflow_o;
    logic              overflow_clr_i;

    int checks = 0;
    int errors = 0;
    int m_w    = 0;           // bench count of accepted writes
    int exp_addr_q[$];        // scoreboard of expected write addresses

    fifo_wptr_full #(
        .PTR_WD    (PTR_WD),
        .AFULL_THR (AFULL_THR)
    ) dut (
        .wclk_i         (wclk_i),
        .wrst_i         (wrst_i),
        .wr_req_i       (wr_req_i),
        .rptr_gray_i    (rptr_gray_i),
        .wen_o          (wen_o),
        .waddr_o        (waddr_o),
        .wptr_gray_o    (wptr_gray_o),
        .full_o         (full_o),
        .afull_o        (afull_o),
        .wcount_o       (wcount_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i)
    );

    always #5 wclk_i = ~wclk_i;

    function automatic logic [PTR_WD:0] gray_of(input int b);
        logic [PTR_WD:0] v;
        v = (PTR_WD+1)'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge wclk_i);
        #1;
    endtask

    // Drive one request cycle (called at edge+1). Checks the combinational
    // enable before the edge and scores the address if a write happens.
    task automatic req_cycle(input logic req, input logic exp_wen, input string tag);
        wr_req_i = req;
        if (req && exp_wen) begin
            exp_addr_q.push_back(m_w % DEPTH);
            m_w++;
        end
        #1;
        chk({tag, "_wen"}, 32'(wen_o), 32'(exp_wen));
        if (wen_o) begin
            if (exp_addr_q.size() == 0) begin
                chk({tag, "_unexpected_write"}, 32'(waddr_o), 32'hFFFF_FFFF);
            end else begin
                chk({tag, "_waddr"}, 32'(waddr_o), 32'(exp_addr_q.pop_front()));
            end
        end
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wen"},      32'(wen_o),       0);
        chk({tag, "_waddr"},    32'(waddr_o),     0);
        chk({tag, "_wptr"},     32'(wptr_gray_o), 0);
        chk({tag, "_full"},     32'(full_o),      0);
        chk({tag, "_afull"},    32'(afull_o),     0);
        chk({tag, "_wcount"},   32'(wcount_o),    0);
        chk({tag, "_overflow"}, 32'(overflow_o),  0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [PTR_WD:0] prev_gray;

        // ---- Reset with a write requested ----
        wrst_i         = 1'b1;
        wr_req_i       = 1'b1;
        rptr_gray_i    = '0;
        overflow_clr_i = 1'b0;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        chk_all_zero("reset_held");

        // ---- Fill: 16 writes, read pointer at 0 ----
        wrst_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            req_cycle(1'b1, 1'b1, "fill");
            chk("fill_wcount", 32'(wcount_o), 32'(i + 1));
            chk("fill_afull",  32'(afull_o),  32'((i + 1) >= AFULL_THR));
            chk("fill_full",   32'(full_o),   32'(i == DEPTH - 1));
        end
        chk("fill_wptr_gray", 32'(wptr_gray_o), 32'h18);
        chk("fill_wcount16",  32'(wcount_o),    16);

        // ---- Requests at full are refused, overflow is sticky ----
        for (int i = 0; i < 3; i++) begin
            req_cycle(1'b1, 1'b0, "ovf");
            chk("ovf_set",  32'(overflow_o),  1);
            chk("ovf_wptr", 32'(wptr_gray_o), 32'h18);
        end
        // Set and clear together: set wins.
        overflow_clr_i = 1'b1;
        req_cycle(1'b1, 1'b0, "ovf_setclr");
        chk("ovf_set_wins", 32'(overflow_o), 1);
        req_cycle(1'b0, 1'b0, "ovf_clr");
        chk("ovf_cleared", 32'(overflow_o), 0);
        overflow_clr_i = 1'b0;
        req_cycle(1'b0, 1'b0, "ovf_idle");
        chk("ovf_stays_clear", 32'(overflow_o), 0);

        // ---- Read pointer advances to 4: full drops exactly 3 edges later ----
        rptr_gray_i = gray_of(4);
        req_cycle(1'b1, 1'b0, "drain1");
        chk("drain_full_e1", 32'(full_o), 1);
        req_cycle(1'b1, 1'b0, "drain2");
        chk("drain_full_e2", 32'(full_o), 1);
        chk("drain_wcount_e2", 32'(wcount_o), 16);
        req_cycle(1'b0, 1'b0, "drain3");
        chk("drain_full_e3",   32'(full_o),   0);
        chk("drain_wcount_e3", 32'(wcount_o), 12);
        chk("drain_afull_e3",  32'(afull_o),  0);
        overflow_clr_i = 1'b1;
        req_cycle(1'b0, 1'b0, "drain_clr");
        overflow_clr_i = 1'b0;

        // ---- Streaming 40 writes, read pointer trailing by 5 (wraps 31->0) ----
        rptr_gray_i = gray_of(m_w - 5);
        for (int i = 0; i < 3; i++) req_cycle(1'b0, 1'b0, "pre_stream");
        chk("pre_stream_wcount", 32'(wcount_o), 5);
        for (int i = 0; i < 40; i++) begin
            prev_gray = wptr_gray_o;
            req_cycle(1'b1, 1'b1, "stream");
            rptr_gray_i = gray_of(m_w - 5);
            chk("stream_gray_1bit", 32'($countones(wptr_gray_o ^ prev_gray)), 1);
            chk("stream_gray_val",  32'(wptr_gray_o), 32'(gray_of(m_w)));
            chk("stream_full",      32'(full_o), 0);
        end
        for (int i = 0; i < 3; i++) req_cycle(1'b0, 1'b0, "post_stream");
        chk("post_stream_wcount", 32'(wcount_o), 5);

        // ---- Async reset mid-burst at wcount 9 ----
        for (int i = 0; i < 4; i++) req_cycle(1'b1, 1'b1, "burst");
        chk("burst_wcount9", 32'(wcount_o), 9);
        wr_req_i = 1'b1;
        #2;
        wrst_i      = 1'b1;
        rptr_gray_i = '0;
        #1;
        chk_all_zero("midrst");
        exp_addr_q.delete();
        m_w = 0;
        tick();
        chk_all_zero("midrst_held");
        wrst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_cycle(1'b1, 1'b1, "resume");
            chk("resume_wcount", 32'(wcount_o), 32'(i + 1));
        end
        req_cycle(1'b0, 1'b0, "end_idle");
        chk("scoreboard_empty", 32'(exp_addr_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
